// File: rtl/ad9648_spi_responder_pkg.sv
// Shared types and constants for the AD9648-style 3-wire SPI responder.
package ad9648_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        WR_DATA,
        RD_DATA,
        DONE
    } spi_state_e;

    localparam int ADDR_W         = 13;
    localparam int INSTR_LEN      = 16;
    localparam int INSTR_RW_BIT   = 15;
    localparam int INSTR_LEN_MSB  = 14;
    localparam int INSTR_LEN_LSB  = 13;
    localparam int INSTR_ADDR_MSB = 12;

    localparam logic [ADDR_W-1:0] ADDR_CHIP_ID  = 13'h001;
    localparam logic [ADDR_W-1:0] ADDR_TRANSFER = 13'h0FF;
    localparam logic [1:0]        STREAM        = 2'b11;

    // Sample edge is the rising sck edge whenever Cpol and Cpha match.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/ad9648_spi_responder_if.sv
// 3-wire SPI pad bundle between the config master and the responder (IOBUF-style sdio split).
interface ad9648_spi_responder_if;

    logic cs_i;
    logic sck_i;
    logic sdio_i;
    logic sdio_o;
    logic sdio_t_o;

    modport master (
        output cs_i,
        output sck_i,
        output sdio_i,
        input  sdio_o,
        input  sdio_t_o
    );

    modport slave (
        input  cs_i,
        input  sck_i,
        input  sdio_i,
        output sdio_o,
        output sdio_t_o
    );

endinterface

// File: rtl/ad9648_spi_responder_edge_sync.sv
// Brings cs/sck/sdio into clk_sys_i and turns synchronized sck transitions into sample/shift strobes.
module spi_edge_sync
    import ad9648_spi_pkg::*;
#(
    parameter bit Cpol = 1'b0,
    parameter bit Cpha = 1'b0
) (
    input  logic clk_sys_i,
    input  logic rst_sys_clk_ni,
    input  logic cs_i,
    input  logic sck_i,
    input  logic sdio_i,
    output logic cs_n_s_o,
    output logic sdio_s_o,
    output logic sample_stb_o,
    output logic shift_stb_o
);

    localparam bit SampleRise = sample_on_rise(Cpol, Cpha);

    logic cs_meta_q, cs_sync_q;
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic sdio_meta_q, sdio_sync_q;
    logic sck_rise, sck_fall;

    always_ff @(posedge clk_sys_i or negedge rst_sys_clk_ni) begin
        if (!rst_sys_clk_ni) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            sck_meta_q  <= Cpol;
            sck_sync_q  <= Cpol;
            sck_prev_q  <= Cpol;
            sdio_meta_q <= 1'b0;
            sdio_sync_q <= 1'b0;
        end else begin
            cs_meta_q   <= cs_i;
            cs_sync_q   <= cs_meta_q;
            sck_meta_q  <= sck_i;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            sdio_meta_q <= sdio_i;
            sdio_sync_q <= sdio_meta_q;
        end
    end

    // sdio travels through the same two stages as sck, so it stays aligned with the strobe.
    assign sck_rise     = sck_sync_q & ~sck_prev_q;
    assign sck_fall     = ~sck_sync_q & sck_prev_q;
    assign sample_stb_o = SampleRise ? sck_rise : sck_fall;
    assign shift_stb_o  = SampleRise ? sck_fall : sck_rise;
    assign cs_n_s_o     = cs_sync_q;
    assign sdio_s_o     = sdio_sync_q;

endmodule

// File: rtl/ad9648_spi_responder.sv
// AD9648 serial-port target: 16-bit instruction, MSB-first data bytes, descending addresses, SDIO turnaround on reads.
//
// state   | meaning
// IDLE    | cs high, sdio released, waiting for cs low
// INSTR   | shifting in the 16-bit instruction
// WR_DATA | shifting in write bytes, committing each complete byte
// RD_DATA | driving read bytes on sdio
// DONE    | byte count reached, sck ignored and sdio released until cs high
module ad9648_spi_responder
    import ad9648_spi_pkg::*;
#(
    parameter int         RegDepth = 256,
    parameter logic [7:0] ChipId   = 8'h88,
    parameter bit         Cpol     = 1'b0,
    parameter bit         Cpha     = 1'b0
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_sys_clk_ni,
    ad9648_spi_responder_if.slave spi,
    output logic                  wr_valid_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [7:0]            wr_data_o,
    output logic                  xfer_o,
    output logic                  busy_o
);

    localparam int MemAw = (RegDepth > 1) ? $clog2(RegDepth) : 1;

    logic cs_n_s, sdio_s, sample_stb, shift_stb;

    spi_edge_sync #(
        .Cpol (Cpol),
        .Cpha (Cpha)
    ) u_edge_sync (
        .clk_sys_i      (clk_sys_i),
        .rst_sys_clk_ni (rst_sys_clk_ni),
        .cs_i           (spi.cs_i),
        .sck_i          (spi.sck_i),
        .sdio_i         (spi.sdio_i),
        .cs_n_s_o       (cs_n_s),
        .sdio_s_o       (sdio_s),
        .sample_stb_o   (sample_stb),
        .shift_stb_o    (shift_stb)
    );

    spi_state_e        state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [14:0]       shreg_q, shreg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        len_q, len_d;
    logic              sdio_q, sdio_d;
    logic              sdio_t_q, sdio_t_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              xfer_q, xfer_d;

    logic [7:0]        regmap_q [RegDepth];

    logic [INSTR_LEN-1:0] instr_w;
    logic [7:0]           byte_in;
    logic [7:0]           rd_byte;
    logic                 addr_in_map;
    logic                 last_byte;

    assign instr_w     = {shreg_q, sdio_s};
    assign byte_in     = {shreg_q[6:0], sdio_s};
    assign addr_in_map = {1'b0, addr_q} < 14'(RegDepth);
    assign last_byte   = (len_q != STREAM) && (byte_cnt_q == len_q);

    // 0x0FF is a strobe, not storage, so it always reads back as zero.
    always_comb begin
        rd_byte = 8'h00;
        if (addr_q == ADDR_CHIP_ID) begin
            rd_byte = ChipId;
        end else if (addr_q != ADDR_TRANSFER && addr_in_map) begin
            rd_byte = regmap_q[addr_q[MemAw-1:0]];
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        addr_d     = addr_q;
        len_d      = len_q;
        sdio_d     = sdio_q;
        sdio_t_d   = sdio_t_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        xfer_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                sdio_t_d = 1'b1;
                sdio_d   = 1'b0;
                if (!cs_n_s) begin
                    state_d    = INSTR;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            INSTR: begin
                if (sample_stb) begin
                    shreg_d   = instr_w[14:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        addr_d  = instr_w[INSTR_ADDR_MSB:0];
                        len_d   = instr_w[INSTR_LEN_MSB:INSTR_LEN_LSB];
                        state_d = instr_w[INSTR_RW_BIT] ? RD_DATA : WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                if (sample_stb) begin
                    shreg_d   = {shreg_q[13:0], sdio_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = '0;
                        if (addr_q == ADDR_TRANSFER) begin
                            xfer_d = byte_in[0];
                        end else if (addr_in_map && addr_q != ADDR_CHIP_ID) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = byte_in;
                        end
                        addr_d     = addr_q - 13'd1;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (last_byte) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            RD_DATA: begin
                // A shift edge at bit 0 is the byte boundary: fetch the byte at the current address.
                if (shift_stb) begin
                    sdio_t_d = 1'b0;
                    if (bit_cnt_q == 4'd0) begin
                        sdio_d  = rd_byte[7];
                        shreg_d = {7'd0, rd_byte[6:0], 1'b0};
                    end else begin
                        sdio_d  = shreg_q[7];
                        shreg_d = {shreg_q[13:0], 1'b0};
                    end
                end
                if (sample_stb) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d  = '0;
                        addr_d     = addr_q - 13'd1;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (last_byte) begin
                            state_d  = DONE;
                            sdio_t_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                sdio_t_d = 1'b1;
            end
            default: begin
                state_d  = IDLE;
                sdio_t_d = 1'b1;
            end
        endcase

        if (state_q != IDLE && cs_n_s) begin
            state_d  = IDLE;
            sdio_t_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_clk_ni) begin
        if (!rst_sys_clk_ni) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            sdio_q     <= 1'b0;
            sdio_t_q   <= 1'b1;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            xfer_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            sdio_q     <= sdio_d;
            sdio_t_q   <= sdio_t_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            xfer_q     <= xfer_d;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_clk_ni) begin
        if (!rst_sys_clk_ni) begin
            for (int i = 0; i < RegDepth; i++) begin
                regmap_q[i] <= 8'h00;
            end
        end else if (wr_valid_q) begin
            regmap_q[wr_addr_q[MemAw-1:0]] <= wr_data_q;
        end
    end

    assign spi.sdio_o   = sdio_q;
    assign spi.sdio_t_o = sdio_t_q;
    assign wr_valid_o   = wr_valid_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign xfer_o       = xfer_q;
    assign busy_o       = ~cs_n_s;

endmodule

// File: tb/tb_ad9648_spi_responder.sv
// Bench for ad9648_spi_responder: bit-banged SPI master plus a register-map reference model.
module tb_ad9648_spi_responder;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        xfer;
    logic        busy;
    logic        mst_oe = 1'b1;
    logic        mst_bit = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int rst_at_bit = -1;

    logic [7:0]  tx_buf [8];
    logic [7:0]  rx_buf [8];
    logic [7:0]  ref_mem [8192];
    logic [20:0] exp_q [$];
    logic [20:0] got_q [$];
    int          exp_xfer = 0;
    int          got_xfer = 0;

    always #5 clk = ~clk;

    ad9648_spi_responder_if sif ();

    // Shared line: responder wins when it drives, otherwise master or pull-up.
    assign sif.sdio_i = !sif.sdio_t_o ? sif.sdio_o : (mst_oe ? mst_bit : 1'b1);

    ad9648_spi_responder dut (
        .clk_sys_i      (clk),
        .rst_sys_clk_ni (rst_n),
        .spi            (sif.slave),
        .wr_valid_o     (wr_valid),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data),
        .xfer_o         (xfer),
        .busy_o         (busy)
    );

    always @(negedge clk) begin
        if (rst_n && wr_valid) got_q.push_back({wr_addr, wr_data});
        if (rst_n && xfer) got_xfer++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int next_addr(input int a);
        return (a == 0) ? 8191 : a - 1;
    endfunction

    function automatic logic [7:0] model_rd(input int a);
        if (a == 1) return 8'h88;
        if (a == 255 || a >= 256) return 8'h00;
        return ref_mem[a];
    endfunction

    task automatic model_write(input int addr, input int nfull);
        int a = addr;
        for (int b = 0; b < nfull; b++) begin
            if (a == 255) begin
                if (tx_buf[b][0]) exp_xfer++;
            end else if (a != 1 && a < 256) begin
                ref_mem[a] = tx_buf[b];
                exp_q.push_back({13'(a), tx_buf[b]});
            end
            a = next_addr(a);
        end
    endtask

    task automatic check_writes();
        check_eq("wr_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq("wr_event", got_q[i], exp_q[i]);
        check_eq("xfer_count", got_xfer, exp_xfer);
        got_q.delete();
        exp_q.delete();
        got_xfer = 0;
        exp_xfer = 0;
    endtask

    task automatic spi_xfer(input logic [15:0] instr, input int nbits);
        logic is_rd;
        is_rd = instr[15];
        mst_oe = 1'b1;
        @(negedge clk);
        sif.cs_i = 1'b0;
        wait_clk(HALF);
        check_eq("busy_active", busy, 1);
        for (int i = 0; i < 16; i++) begin
            mst_bit = instr[15-i];
            wait_clk(HALF);
            sif.sck_i = 1'b1;
            if (is_rd && i == 15) begin
                wait_clk(4);
                check_eq("sdio_t_instr", sif.sdio_t_o, 1);
                wait_clk(HALF - 4);
            end else begin
                wait_clk(HALF);
            end
            sif.sck_i = 1'b0;
        end
        if (is_rd) mst_oe = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            mst_bit = tx_buf[k/8][7-(k%8)];
            wait_clk(HALF);
            if (is_rd && k == 0) check_eq("sdio_t_turn", sif.sdio_t_o, 0);
            sif.sck_i = 1'b1;
            rx_buf[k/8][7-(k%8)] = sif.sdio_i;
            if (k == rst_at_bit) begin
                check_eq("sdio_t_pre_rst", sif.sdio_t_o, 0);
                rst_n = 1'b0;
                #1;
                check_eq("sdio_t_async_rst", sif.sdio_t_o, 1);
                check_eq("busy_async_rst", busy, 0);
            end
            wait_clk(HALF);
            sif.sck_i = 1'b0;
        end
        wait_clk(HALF);
        sif.cs_i = 1'b1;
        wait_clk(4);
        check_eq("sdio_t_release", sif.sdio_t_o, 1);
        check_eq("busy_idle", busy, 0);
        mst_oe = 1'b1;
        wait_clk(4);
    endtask

    task automatic do_write(input int addr, input int nfull, input int npart, input bit stream);
        logic [1:0]  w;
        logic [12:0] a13;
        a13 = 13'(addr);
        w = stream ? 2'b11 : 2'(nfull + ((npart > 0) ? 1 : 0) - 1);
        spi_xfer({1'b0, w, a13}, nfull * 8 + npart);
        model_write(addr, nfull);
        check_writes();
    endtask

    task automatic do_read(input int addr, input int n, input bit stream);
        logic [1:0]  w;
        logic [12:0] a13;
        int          a;
        a13 = 13'(addr);
        w = stream ? 2'b11 : 2'(n - 1);
        spi_xfer({1'b1, w, a13}, n * 8);
        a = addr;
        for (int b = 0; b < n; b++) begin
            check_eq($sformatf("rd_data@%0h", a), rx_buf[b], model_rd(a));
            a = next_addr(a);
        end
        check_writes();
    endtask

    function automatic int pick_addr();
        case ($urandom_range(0, 9))
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 8'h14;
            4: return 8'hFE;
            5: return 8'hFF;
            6: return 9'h100;
            7: return 13'h1FFF;
            8: return $urandom_range(0, 9'h1FF);
            default: return $urandom_range(0, 8'h3F);
        endcase
    endfunction

    initial begin
        sif.cs_i = 1'b1;
        sif.sck_i = 1'b0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
        wait_clk(3);
        check_eq("rst_sdio_t", sif.sdio_t_o, 1);
        check_eq("rst_sdio_o", sif.sdio_o, 0);
        check_eq("rst_wr_valid", wr_valid, 0);
        check_eq("rst_xfer", xfer, 0);
        check_eq("rst_busy", busy, 0);
        rst_n = 1'b1;
        wait_clk(4);

        tx_buf[0] = 8'h5A;
        do_write(8'h14, 1, 0, 1'b0);
        do_read(8'h14, 1, 1'b0);
        do_read(1, 1, 1'b0);

        tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33;
        do_write(8'h16, 3, 0, 1'b0);
        do_read(8'h16, 3, 1'b1);

        tx_buf[0] = 8'h01;
        do_write(8'hFF, 1, 0, 1'b0);
        do_read(8'hFF, 1, 1'b0);

        tx_buf[0] = 8'hC3;
        do_write(8'h20, 0, 5, 1'b0);
        do_read(8'h20, 1, 1'b0);

        rst_at_bit = 2;
        spi_xfer({1'b1, 2'b00, 13'h014}, 3);
        rst_at_bit = -1;
        wait_clk(3);
        rst_n = 1'b1;
        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
        got_q.delete();
        got_xfer = 0;
        wait_clk(4);
        do_read(8'h14, 1, 1'b0);
        do_read(8'h16, 3, 1'b1);
        tx_buf[0] = 8'hA7;
        do_write(8'h30, 1, 0, 1'b0);
        do_read(8'h30, 1, 1'b0);

        for (int it = 0; it < 30; it++) begin
            int addr, n, op;
            bit stream;
            addr = pick_addr();
            op = $urandom_range(0, 4);
            stream = ($urandom_range(0, 3) == 0);
            n = stream ? $urandom_range(1, 5) : $urandom_range(1, 3);
            for (int b = 0; b < 8; b++) tx_buf[b] = 8'($urandom);
            if (op <= 1) do_write(addr, n, 0, stream);
            else if (op == 2) do_write(addr, n - 1, $urandom_range(1, 7), stream);
            else do_read(addr, n, stream);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
